// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//
// Hazard sequencer for a 5-stage IF/ID/EX/MEM/WB RISC-V pipeline.
// - Combinational stall/flush strobes per stage and EX operand forward selects.
// - Freezes the whole pipe while a data-memory access is outstanding and traps
//   (sticky MemErr, permanent full stall) if the access exceeds MEM_TIMEOUT cycles.
// - Saturating performance counters for stalled cycles and branch flushes.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   IdValid, IdRs1, IdRs2            instruction in ID and its source registers
//   ExRs1, ExRs2, ExRd               EX source/destination registers
//   ExRegWrite, ExMemToReg           EX writes a register / is a load
//   ExBranchTaken                    branch resolved taken in EX
//   MemRd, MemRegWrite               MEM destination register and write enable
//   WbRd, WbRegWrite                 WB destination register and write enable
//   MemReq, MemReady                 data access issued / completing this cycle
//   StallIF/ID/EX/MEM                hold the corresponding pipeline register
//   FlushID, FlushEX                 load NOP into IF/ID resp. ID/EX
//   ForwardA, ForwardB               00 regfile, 10 from MEM, 01 from WB
//   MemErr                           sticky memory-timeout flag
//   StallCycles, FlushCount          saturating performance counters

module pipeline_hazard_ctrl #(
    parameter int unsigned REG_AW      = 5,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              IdValid,
    input  logic [REG_AW-1:0] IdRs1,
    input  logic [REG_AW-1:0] IdRs2,
    input  logic [REG_AW-1:0] ExRs1,
    input  logic [REG_AW-1:0] ExRs2,
    input  logic [REG_AW-1:0] ExRd,
    input  logic              ExRegWrite,
    input  logic              ExMemToReg,
    input  logic              ExBranchTaken,
    input  logic [REG_AW-1:0] MemRd,
    input  logic              MemRegWrite,
    input  logic [REG_AW-1:0] WbRd,
    input  logic              WbRegWrite,
    input  logic              MemReq,
    input  logic              MemReady,
    output logic              StallIF,
    output logic              StallID,
    output logic              StallEX,
    output logic              StallMEM,
    output logic              FlushID,
    output logic              FlushEX,
    output logic [1:0]        ForwardA,
    output logic [1:0]        ForwardB,
    output logic              MemErr,
    output logic [CNT_W-1:0]  StallCycles,
    output logic [CNT_W-1:0]  FlushCount
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {StRun, StMemWait, StTrap} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WAIT_W-1:0]  r_wait;
    logic [WAIT_W-1:0]  w_wait_next;
    logic               r_mem_err;
    logic               r_br_pend;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;

    logic               w_mem_hold;
    logic               w_branch;
    logic               w_load_use;
    logic               w_stall_front;
    logic               w_flush_ex;

    // FSM next state and wait counter
    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait;
        case (r_state)
            StRun: begin
                w_wait_next = '0;
                if (MemReq && !MemReady) begin
                    w_state_next = StMemWait;
                end
            end
            StMemWait: begin
                if (MemReady) begin
                    w_state_next = StRun;
                    w_wait_next  = '0;
                end else begin
                    w_wait_next = r_wait + 1'b1;
                    if (w_wait_next >= TIMEOUT_V) begin
                        w_state_next = StTrap;
                    end
                end
            end
            StTrap: begin
                w_state_next = StTrap;
            end
            default: begin
                w_state_next = StRun;
                w_wait_next  = '0;
            end
        endcase
    end

    // Hazard decode; priority is memory hold > branch > load-use
    always_comb begin
        w_mem_hold = (MemReq && !MemReady) || (r_state == StTrap);
        // A branch seen while frozen is remembered and flushed once the hold lifts
        w_branch   = !w_mem_hold && (ExBranchTaken || r_br_pend);
        w_load_use = !w_mem_hold && !w_branch && IdValid && ExMemToReg && ExRegWrite
                     && (ExRd != '0) && ((ExRd == IdRs1) || (ExRd == IdRs2));
        w_stall_front = w_mem_hold || w_load_use;
        w_flush_ex    = w_branch || w_load_use;
    end

    // Strobes are forced low while reset is asserted
    always_comb begin
        StallIF  = rst_n && w_stall_front;
        StallID  = rst_n && w_stall_front;
        StallEX  = rst_n && w_mem_hold;
        StallMEM = rst_n && w_mem_hold;
        FlushID  = rst_n && w_branch;
        FlushEX  = rst_n && w_flush_ex;
    end

    // Forwarding: the MEM result is younger than WB, so it wins
    always_comb begin
        ForwardA = 2'b00;
        ForwardB = 2'b00;
        if (MemRegWrite && (MemRd != '0) && (MemRd == ExRs1)) begin
            ForwardA = 2'b10;
        end else if (WbRegWrite && (WbRd != '0) && (WbRd == ExRs1)) begin
            ForwardA = 2'b01;
        end
        if (MemRegWrite && (MemRd != '0) && (MemRd == ExRs2)) begin
            ForwardB = 2'b10;
        end else if (WbRegWrite && (WbRd != '0) && (WbRd == ExRs2)) begin
            ForwardB = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StRun;
            r_wait      <= '0;
            r_mem_err   <= 1'b0;
            r_br_pend   <= 1'b0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_wait    <= w_wait_next;
            r_mem_err <= r_mem_err || (w_state_next == StTrap);
            r_br_pend <= w_mem_hold && (ExBranchTaken || r_br_pend);
            if (w_stall_front && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_branch && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign MemErr      = r_mem_err;
    assign StallCycles = r_stall_cnt;
    assign FlushCount  = r_flush_cnt;

endmodule
